mem_access_unit: RTL and testbench



---
 rtl/mem_access_unit.sv | 155 +++++++++++++++
 tb/tb_mem_access_unit.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_unit.sv
// Load/store sequencer between the processor datapath and the data RAM.
// Optional one-entry last-read cache enabled by defining MAU_READ_CACHE_EN.
// Request handshake: a request transfers at a posedge where reqValid && reqReady;
// reqReady depends only on state, and reqWrite/reqAddr/reqWData are sampled at that edge.
module mem_access_unit #(
    parameter int width   = 16,
    parameter int length  = 8,
    parameter int TIMEOUT = 4
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              reqValid,
    input  logic              reqWrite,
    input  logic [length-1:0] reqAddr,
    input  logic [width-1:0]  reqWData,
    output logic              reqReady,
    output logic              respValid,
    output logic              respError,
    output logic [width-1:0]  respData,
    output logic              ramWriteEnable,
    output logic              ramReadEnable,
    output logic [length-1:0] ramAddr,
    output logic [length-1:0] ramReadAddr,
    output logic [width-1:0]  ramWriteData,
    input  logic              ramDataReady,
    input  logic [width-1:0]  ramReadData
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        READ  = 2'd2
    } stateType;

    localparam logic [3:0] timeoutLimit = 4'(TIMEOUT);

    stateType   state;
    logic [3:0] timeoutCount;
    logic       readTimeout;
    logic       cacheHit;

    assign reqReady    = (state == IDLE);
    assign readTimeout = (timeoutCount + 4'd1 == timeoutLimit);

`ifdef MAU_READ_CACHE_EN
    logic              cacheValid;
    logic [length-1:0] cacheTag;
    logic [width-1:0]  cacheData;
    logic              hitPending;

    assign cacheHit = cacheValid && (cacheTag == reqAddr);

    // Cache contents cannot change between a hit's accept edge and its response edge.
    always_ff @(posedge clk) begin
        if (clr) begin
            cacheValid <= 1'b0;
            cacheTag   <= '0;
            cacheData  <= '0;
        end else begin
            if (state == IDLE && reqValid && reqWrite && cacheHit) begin
                cacheData <= reqWData;
            end
            if (state == READ) begin
                if (ramDataReady) begin
                    cacheValid <= 1'b1;
                    cacheTag   <= ramReadAddr;
                    cacheData  <= ramReadData;
                end else if (readTimeout) begin
                    cacheValid <= 1'b0;
                end
            end
        end
    end
`else
    assign cacheHit = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (clr) begin
            state          <= IDLE;
            timeoutCount   <= '0;
            respValid      <= 1'b0;
            respError      <= 1'b0;
            respData       <= '0;
            ramWriteEnable <= 1'b0;
            ramReadEnable  <= 1'b0;
            ramAddr        <= '0;
            ramReadAddr    <= '0;
            ramWriteData   <= '0;
`ifdef MAU_READ_CACHE_EN
            hitPending     <= 1'b0;
`endif
        end else begin
            respValid <= 1'b0;
            respError <= 1'b0;
`ifdef MAU_READ_CACHE_EN
            hitPending <= 1'b0;
            if (hitPending) begin
                respValid <= 1'b1;
                respData  <= cacheData;
            end
`endif
            case (state)
                IDLE: begin
                    if (reqValid) begin
                        ramAddr      <= reqAddr;
                        ramReadAddr  <= reqAddr;
                        ramWriteData <= reqWData;
                        if (reqWrite) begin
                            state          <= WRITE;
                            ramWriteEnable <= 1'b1;
                        end else if (cacheHit) begin
`ifdef MAU_READ_CACHE_EN
                            hitPending <= 1'b1;
`endif
                        end else begin
                            state         <= READ;
                            ramReadEnable <= 1'b1;
                            timeoutCount  <= '0;
                        end
                    end
                end
                WRITE: begin
                    state          <= IDLE;
                    ramWriteEnable <= 1'b0;
                    respValid      <= 1'b1;
                end
                READ: begin
                    // dataReady wins over the counter on the edge the limit is reached.
                    if (ramDataReady) begin
                        state         <= IDLE;
                        ramReadEnable <= 1'b0;
                        respValid     <= 1'b1;
                        respData      <= ramReadData;
                    end else if (readTimeout) begin
                        state         <= IDLE;
                        ramReadEnable <= 1'b0;
                        respValid     <= 1'b1;
                        respError     <= 1'b1;
                        respData      <= '0;
                        timeoutCount  <= timeoutCount + 4'd1;
                    end else begin
                        timeoutCount <= timeoutCount + 4'd1;
                    end
                end
                default: begin
                    state          <= IDLE;
                    ramWriteEnable <= 1'b0;
                    ramReadEnable  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: negedge RAM model with per-request stall, directed
// steps from the test plan, then randomized traffic checked against a request-level model.
module tb_mem_access_unit;

    localparam int W   = 16;
    localparam int L   = 8;
    localparam int TMO = 4;
`ifdef MAU_READ_CACHE_EN
    localparam bit cacheEn = 1'b1;
`else
    localparam bit cacheEn = 1'b0;
`endif

    logic         clk;
    logic         clr;
    logic         reqValid;
    logic         reqWrite;
    logic [L-1:0] reqAddr;
    logic [W-1:0] reqWData;
    logic         reqReady;
    logic         respValid;
    logic         respError;
    logic [W-1:0] respData;
    logic         ramWriteEnable;
    logic         ramReadEnable;
    logic [L-1:0] ramAddr;
    logic [L-1:0] ramReadAddr;
    logic [W-1:0] ramWriteData;
    logic         ramDataReady = 1'b0;
    logic [W-1:0] ramReadData = '0;

    mem_access_unit #(.width(W), .length(L), .TIMEOUT(TMO)) dut (
        .clk(clk), .clr(clr),
        .reqValid(reqValid), .reqWrite(reqWrite), .reqAddr(reqAddr), .reqWData(reqWData),
        .reqReady(reqReady),
        .respValid(respValid), .respError(respError), .respData(respData),
        .ramWriteEnable(ramWriteEnable), .ramReadEnable(ramReadEnable),
        .ramAddr(ramAddr), .ramReadAddr(ramReadAddr), .ramWriteData(ramWriteData),
        .ramDataReady(ramDataReady), .ramReadData(ramReadData)
    );

    // Clock: half period 20 ns, longer than the RAM read-data delay.
    initial clk = 1'b0;
    always #20 clk = ~clk;

    // RAM model: acts on negedge; holds dataReady low for stallReq read cycles.
    logic [W-1:0] ramMem [256] = '{default: '0};
    int           stallReq = 0;
    int           readCycle = 0;

    always @(negedge clk) begin
        if (ramWriteEnable) ramMem[ramAddr] = ramWriteData;
        if (ramReadEnable) begin
            if (readCycle < stallReq) begin
                ramDataReady = 1'b0;
            end else begin
                ramDataReady = 1'b1;
                ramReadData  = ramMem[ramReadAddr];
            end
            readCycle++;
        end else begin
            readCycle = 0;
        end
    end

    // Reference model state: memory image, last-read cache, expected respData register.
    logic [W-1:0] refMem [256] = '{default: '0};
    logic         refCacheValid = 1'b0;
    logic [L-1:0] refCacheTag = '0;
    logic [W-1:0] expData = '0;
    logic [W-1:0] expQ [$];

    int vectors = 0;
    int miscompares = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One request from IDLE, waited to completion and checked against the model.
    task automatic doReq(input logic wr, input logic [L-1:0] addr,
                         input logic [W-1:0] data, input int stall);
        logic hit;
        int   expLat;
        logic expErr;
        int   lat;
        hit = cacheEn && !wr && refCacheValid && (refCacheTag == addr);
        if (wr) begin
            expLat = 1;
            expErr = 1'b0;
            refMem[addr] = data;
        end else if (hit) begin
            expLat  = 1;
            expErr  = 1'b0;
            expData = refMem[addr];
        end else if (stall < TMO) begin
            expLat        = stall + 1;
            expErr        = 1'b0;
            expData       = refMem[addr];
            refCacheValid = 1'b1;
            refCacheTag   = addr;
        end else begin
            expLat        = TMO;
            expErr        = 1'b1;
            expData       = '0;
            refCacheValid = 1'b0;
        end
        expQ.push_back(expData);

        check("ready_idle", reqReady, 1);
        reqValid = 1'b1;
        reqWrite = wr;
        reqAddr  = addr;
        reqWData = data;
        stallReq = stall;
        tick();
        reqValid = 1'b0;
        check("no_early_resp", respValid, 0);
        check("we_after_accept", ramWriteEnable, wr);
        check("re_after_accept", ramReadEnable, !wr && !hit);
        check("ready_after_accept", reqReady, hit);

        lat = 0;
        while (respValid !== 1'b1 && lat < 20) begin
            tick();
            lat++;
        end
        check("resp_seen", respValid, 1);
        check("latency", lat, expLat);
        check("resp_err", respError, expErr);
        check("resp_data", respData, expQ.pop_front());
        check("enables_low", {ramWriteEnable, ramReadEnable}, 0);
        check("ready_on_resp", reqReady, 1);
        tick();
        check("resp_one_cycle", respValid, 0);
    endtask

    initial begin
        clr      = 1'b1;
        reqValid = 1'b1;
        reqWrite = 1'b1;
        reqAddr  = 8'h33;
        reqWData = 16'hAAAA;

        // Reset with a store presented in the same cycles: reset must win.
        tick();
        tick();
        check("rst_ready", reqReady, 1);
        check("rst_we", ramWriteEnable, 0);
        check("rst_re", ramReadEnable, 0);
        check("rst_resp_valid", respValid, 0);
        check("rst_resp_err", respError, 0);
        check("rst_resp_data", respData, 0);
        check("rst_ram_addr", ramAddr, 0);
        check("rst_ram_raddr", ramReadAddr, 0);
        check("rst_ram_wdata", ramWriteData, 0);
        clr      = 1'b0;
        reqValid = 1'b0;
        tick();
        check("rst_no_resp", respValid, 0);

        // Store then load.
        doReq(1'b1, 8'h05, 16'hBEEF, 0);
        doReq(1'b0, 8'h05, 16'h0000, 0);

        // Read timeout: dataReady never rises.
        doReq(1'b0, 8'h10, 16'h0000, 50);

        // Reset in the middle of a stalled read.
        reqValid = 1'b1;
        reqWrite = 1'b0;
        reqAddr  = 8'h05;
        stallReq = 50;
        tick();
        reqValid = 1'b0;
        check("mid_re_high", ramReadEnable, 1);
        tick();
        clr = 1'b1;
        tick();
        clr = 1'b0;
        check("mid_rst_resp", respValid, 0);
        check("mid_rst_re", ramReadEnable, 0);
        check("mid_rst_we", ramWriteEnable, 0);
        check("mid_rst_ready", reqReady, 1);
        check("mid_rst_data", respData, 0);
        expData       = '0;
        refCacheValid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("mid_rst_quiet", respValid, 0);
        end
        doReq(1'b0, 8'h05, 16'h0000, 0);

        // Back-to-back with reqValid held high: store 0x20 then load 0x20.
        reqValid = 1'b1;
        reqWrite = 1'b1;
        reqAddr  = 8'h20;
        reqWData = 16'h1234;
        stallReq = 0;
        refMem[8'h20] = 16'h1234;
        tick();
        check("b2b_we", ramWriteEnable, 1);
        check("b2b_ready_write", reqReady, 0);
        check("b2b_no_resp", respValid, 0);
        reqWrite = 1'b0;
        tick();
        check("b2b_store_resp", respValid, 1);
        check("b2b_store_err", respError, 0);
        check("b2b_ready_idle", reqReady, 1);
        check("b2b_we_low", ramWriteEnable, 0);
        tick();
        reqValid = 1'b0;
        check("b2b_resp_one_cycle", respValid, 0);
        check("b2b_re", ramReadEnable, 1);
        check("b2b_ready_read", reqReady, 0);
        tick();
        check("b2b_load_resp", respValid, 1);
        check("b2b_load_data", respData, 16'h1234);
        check("b2b_load_err", respError, 0);
        expData       = 16'h1234;
        refCacheValid = 1'b1;
        refCacheTag   = 8'h20;
        tick();
        check("b2b_load_one_cycle", respValid, 0);

        // Stale dataReady from an earlier read must not complete a later load early.
        doReq(1'b0, 8'h05, 16'h0000, 0);
        doReq(1'b1, 8'h06, 16'h5A5A, 0);
        doReq(1'b0, 8'h06, 16'h0000, 0);

        // Repeated load, write-through store, reload of the same address.
        doReq(1'b0, 8'h05, 16'h0000, 0);
        doReq(1'b0, 8'h05, 16'h0000, 0);
        doReq(1'b1, 8'h05, 16'h0001, 0);
        doReq(1'b0, 8'h05, 16'h0000, 0);

        // Randomized traffic over a small address set so cache hits and overwrites occur.
        for (int a = 0; a < 8; a++) begin
            doReq(1'b1, L'(a), W'($urandom), 0);
        end
        for (int n = 0; n < 60; n++) begin
            logic         wr;
            logic [L-1:0] addr;
            int           stall;
            wr    = ($urandom_range(0, 2) == 0);
            addr  = L'($urandom_range(0, 7));
            stall = ($urandom_range(0, 3) == 0) ? $urandom_range(TMO - 1, TMO + 2)
                                                : $urandom_range(0, 2);
            doReq(wr, addr, W'($urandom), stall);
            if ($urandom_range(0, 3) == 0) tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
